// File: rtl/fifo_pkg.sv
// Shared constants for the FWFT FIFO slice: the block RAM size and the
// width-to-depth mapping used to size pointers and counters.
package fifo_pkg;

    localparam int RAM_BITS = 4096;

    function automatic int depth_for_width(input int width);
        return RAM_BITS / width;
    endfunction

endpackage

// File: rtl/dp_bram4096.sv
// 4096-bit simple dual-port block RAM: write on port A, registered read on
// port B with one cycle of latency. Contents are not reset.
module dp_bram4096
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int DEPTH = depth_for_width(WIDTH),
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk_a,
    input  logic             we_a,
    input  logic [ADDRW-1:0] addr_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             clk_b,
    input  logic             re_b,
    input  logic [ADDRW-1:0] addr_b,
    output logic [WIDTH-1:0] dout_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_a) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk_b) begin
        if (re_b) begin
            rd_data_q <= mem[addr_b];
        end
    end

    assign dout_b = rd_data_q;

endmodule

// File: rtl/fifo_obuf.sv
// Two-entry output skid buffer for the FWFT FIFO. The head entry drives
// rd_data; when the last word is popped the head stays put so rd_data holds.
module fifo_obuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [1:0]       cnt
);

    logic [1:0][WIDTH-1:0] entry_q, entry_d;
    logic                  head_q, head_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  pop;
    logic                  wr_idx;

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        pop     = rd_en && (cnt_q != 2'd0);
        // With one entry held the free slot is the other one; otherwise
        // (empty, or full with a pop freeing the head) it is the head slot.
        wr_idx  = head_q ^ (cnt_q == 2'd1);
        if (wr_en) begin
            entry_d[wr_idx] = wr_data;
        end
        if (pop && !(cnt_q == 2'd1 && !wr_en)) begin
            head_d = ~head_q;
        end
        cnt_d = cnt_q + 2'(wr_en) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            head_q  <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_data = entry_q[head_q];
    assign valid   = (cnt_q != 2'd0);
    assign cnt     = cnt_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO on top of dp_bram4096. A read is
// prefetched whenever the output buffer has room, hiding the RAM latency.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int DEPTH = depth_for_width(WIDTH),
    localparam int ADDRW = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 2) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_in,
    output logic [CNTW-1:0]  level_out
);

    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  ram_cnt_q, ram_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic             ready_out_q, ready_out_d;
    logic             push, pop, rd_issue;
    logic [1:0]       obuf_cnt;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        push = valid_in && ready_out_q;
        pop  = valid_out && ready_in;
        // Words in or heading to the output buffer after this edge must fit in two slots.
        rd_issue = (ram_cnt_q != '0) &&
                   ({1'b0, obuf_cnt} + 3'(rd_pending_q) < 3'd2 + 3'(pop));
        wr_ptr_d     = push     ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_cnt_d    = ram_cnt_q + CNTW'(push) - CNTW'(rd_issue);
        rd_pending_d = rd_issue;
        ready_out_d  = (ram_cnt_d != CNTW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            ready_out_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pending_q <= rd_pending_d;
            ready_out_q  <= ready_out_d;
        end
    end

    dp_bram4096 #(.WIDTH(WIDTH)) u_ram (
        .clk_a  (clk),
        .we_a   (push),
        .addr_a (wr_ptr_q),
        .din_a  (data_in),
        .clk_b  (clk),
        .re_b   (rd_issue),
        .addr_b (rd_ptr_q),
        .dout_b (ram_rdata)
    );

    fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_pending_q),
        .wr_data (ram_rdata),
        .rd_en   (pop),
        .rd_data (data_out),
        .valid   (valid_out),
        .cnt     (obuf_cnt)
    );

    assign ready_out = ready_out_q;
    assign level_out = ram_cnt_q + CNTW'(rd_pending_q) + CNTW'(obuf_cnt);

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: a queue model of the FIFO is checked
// against the DUT every cycle, alongside directed literal expectations.
module tb_sync_fifo_fwft;

    localparam int DEPTH = 512;
    localparam int CNTW  = 11;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic [7:0]      data_in;
    logic            ready_out;
    logic            valid_out;
    logic [7:0]      data_out;
    logic            ready_in;
    logic [CNTW-1:0] level_out;

    int testsRun    = 0;
    int testsFailed = 0;

    sync_fifo_fwft #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .level_out (level_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: every held word carries the edge it was pushed on; the head is
    // visible two edges later, and the output holds the last popped word.
    typedef struct {
        int         stamp;
        logic [7:0] data;
    } entry_t;

    entry_t     modelQ[$];
    entry_t     newEntry;
    int         cycleNum = 0;
    logic [7:0] lastOut  = 8'h00;
    bit         modelReady = 1'b0;
    bit         doPush, doPop;
    bit         expValid;
    logic [7:0] expData;

    function automatic bit modelValid();
        return (modelQ.size() != 0) && (modelQ[0].stamp <= cycleNum - 2);
    endfunction

    task automatic compare(input string name, input int got, input int exp);
        testsRun++;
        if (got != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            lastOut    = 8'h00;
            modelReady = 1'b0;
        end else begin
            doPush = valid_in && modelReady;
            doPop  = modelValid() && ready_in;
            cycleNum++;
            if (doPop) begin
                lastOut = modelQ[0].data;
                void'(modelQ.pop_front());
            end
            if (doPush) begin
                newEntry.stamp = cycleNum;
                newEntry.data  = data_in;
                modelQ.push_back(newEntry);
            end
            modelReady = (modelQ.size() != DEPTH + 2);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            expValid = modelValid();
            expData  = expValid ? modelQ[0].data : lastOut;
            compare("model_valid_out", int'(valid_out), int'(expValid));
            compare("model_data_out",  int'(data_out),  int'(expData));
            compare("model_level_out", int'(level_out), modelQ.size());
            compare("model_ready_out", int'(ready_out), int'(modelReady));
        end
    end

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input bit expReady, input bit expValid_,
                               input logic [7:0] expData_, input int expLevel);
        compare({name, "_ready_out"}, int'(ready_out), int'(expReady));
        compare({name, "_valid_out"}, int'(valid_out), int'(expValid_));
        compare({name, "_data_out"},  int'(data_out),  int'(expData_));
        compare({name, "_level_out"}, int'(level_out), expLevel);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        ready_in = 1'b0;
        #1;
        checkOutput("in_reset", 1'b0, 1'b0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("after_reset", 1'b1, 1'b0, 8'h00, 0);

        // Single word latency and pop.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compare("single_not_yet_visible", int'(valid_out), 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single_visible", 1'b1, 1'b1, 8'hA5, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("single_popped", 1'b1, 1'b0, 8'hA5, 0);

        // Fill to capacity, try one extra push, then drain in order.
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("fill_full", 1'b0, 1'b1, 8'h00, DEPTH + 2);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("fill_push_ignored", 1'b0, 1'b1, 8'h00, DEPTH + 2);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_first_pop", 1'b1, 1'b1, 8'h01, DEPTH + 1);
        for (int i = 0; i < DEPTH + 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_done", 1'b1, 1'b0, 8'h01, 0);

        // Full-rate streaming.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            compare("stream_level_le3", int'(level_out <= 3), 1);
        end
        checkOutput("stream_end", 1'b1, 1'b1, 8'(997), 3);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        compare("stream_drained_level", int'(level_out), 0);

        // Random backpressure on both sides.
        for (int i = 0; i < 5000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        compare("random_drained_level", int'(level_out), 0);

        // Asynchronous reset with words in flight.
        for (int i = 0; i < 37; i++) begin
            applyStimulus(1'b1, 8'(i + 100), 1'b0);
        end
        compare("pre_reset_level", int'(level_out), 37);
        valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 1'b0, 1'b0, 8'h00, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_reset", 1'b1, 1'b0, 8'h00, 0);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_reset_word", 1'b1, 1'b1, 8'h3C, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_reset_drained", 1'b1, 1'b0, 8'h3C, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
